regfile_datapath_pipe: RTL
==========================

REGFILE_DATAPATH_PIPE -- requirements
Module: regfile_datapath_pipe

Interface
- REQ-001 Parameter WIDTH, default 16, datapath and register width (>=8).
- REQ-002 Parameter NREGS, default 16, number of general registers (power of two, >=2); AW = clog2(NREGS).
- REQ-003 clk  input  1  rising-edge clock for all state.
- REQ-004 reset  input  1  asynchronous, active-low reset.
- REQ-005 in_valid  input  1  instruction offered this cycle.
- REQ-006 in_ready  output  1  block accepts the offered instruction; a transfer occurs on an edge where in_valid and in_ready are both 1.
- REQ-007 opcode  input  4  operation select (REQ-015).
- REQ-008 a_sel, b_sel, dst_sel  input  AW each  operand A register, operand B register, destination register.
- REQ-009 use_imm  input  1  1 selects immediate as operand B instead of register b_sel.
- REQ-010 immediate  input  WIDTH  operand B when use_imm=1.
- REQ-011 wb_en  input  1  write the result to dst_sel (ignored for CMP and NOP).
- REQ-012 flags  output  5  {N,C,F,Z,L} = flags[4:0]; carry is flags[3].
- REQ-013 wb_valid, wb_addr, wb_data  output  1/AW/WIDTH  registered retirement report.
- REQ-014 dbg_sel input AW, dbg_data output WIDTH  combinational read of the register file (no bypass).

Function
- REQ-015 Opcodes: 0 ADD, 1 ADDC (A+B+C), 2 SUB (A-B), 3 CMP (A-B, no write), 4 AND, 5 OR, 6 XOR, 7 MOV (B), 8 LSH (A << B[clog2(WIDTH)-1:0], logical), 9 RSH (logical right, same count), 10 MUL (low WIDTH bits of A*B, unsigned), 11-15 NOP (no write, no flag change, still retire).
- REQ-016 Two stages: ID (instruction latched on transfer; operands read during ID cycle) and EX (ALU; regfile and flags written on the edge ending EX).
- REQ-017 Operands are latched into EX on the ID->EX advance edge; if the EX instruction completes on that same edge with write enabled and dst_sel equal to a_sel (resp. b_sel, use_imm=0), its result is used instead of the stale register (bypass).
- REQ-018 ADDC carry-in is read from the flags register during EX; no flag bypass is needed.
- REQ-019 Single-cycle ops occupy EX one cycle; back-to-back issue sustains one instruction per cycle; accept at edge N -> regfile/flags updated at edge N+2.
- REQ-020 MUL is iterative shift-add, one multiplier bit per cycle, occupying EX exactly WIDTH cycles; result written on the edge ending the last cycle.
- REQ-021 EX states: IDLE, EXEC (single cycle), MUL_RUN (count 0..WIDTH-1); MUL_RUN -> IDLE/EXEC on count WIDTH-1.
- REQ-022 in_ready = ID empty, or ID advancing this cycle; ID advances when EX is IDLE or completing; a full ID with EX in MUL_RUN not at final count drops in_ready.
- REQ-023 Flags: ADD/ADDC/SUB update C (carry out; SUB/CMP: C=1 on borrow, i.e. A<B unsigned) and F (signed overflow); SUB/CMP update L=(A<B unsigned); all ops except NOP update Z=(result==0) and N=result[WIDTH-1] (CMP uses A-B); unlisted flags hold.
- REQ-024 ADD/SUB results wrap modulo 2^WIDTH; shift counts >= WIDTH are not possible by construction (count field truncated).
- REQ-025 wb_valid pulses 1 for exactly the cycle after each retirement edge, with wb_addr=dst_sel and wb_data=result; wb_valid also pulses for CMP/NOP/wb_en=0 retirements, with wb_data=result (0 for NOP).
- REQ-026 Simultaneous transfer into ID and ID->EX advance on one edge is legal and loses no instruction.

Reset
- REQ-027 reset=0 asynchronously clears all registers, flags, ID/EX valid, MUL counter/accumulator, wb_valid, wb_addr, wb_data to 0; EX state to IDLE.
- REQ-028 While reset=0, in_ready=0; in_ready=1 from the first edge after reset deasserts.
- REQ-029 Reset during MUL_RUN aborts the multiply with no register or flag write.

Verification
- REQ-030 ADD r1=0x7FFF, imm 0x0001 -> r2=0x8000, N=1,F=1,C=0,Z=0; wb_valid at N+2 cycle.
- REQ-031 ADD r1<-r1+1 issued back-to-back three times from r1=5 -> r1=8, in_ready stays 1 (bypass).
- REQ-032 SUB 0x0003-0x0005 then ADDC 0+0 -> 0xFFFE, C=1,L=1; ADDC result 0x0001.
- REQ-033 MUL 0x00FF*0x0101 (WIDTH=16) -> 0xFFFF after 16 EX cycles; next instruction held, in_ready low until the final cycle.
- REQ-034 Assert reset mid-MUL -> all outputs 0, dbg_data 0 for every register, no wb_valid.
- REQ-035 WIDTH=8, NREGS=4 build: LSH 0x81 by imm 1 -> 0x02, Z=0, N=0.

Source files
------------

// File: rtl/regfile_datapath_pipe.sv
// regfile_datapath_pipe: two-stage (ID/EX) register-file ALU datapath with an iterative multiplier
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready         instruction handshake; opcode, a_sel, b_sel, dst_sel,
//                               use_imm, immediate, wb_en describe the offered instruction
//   flags                       {N,C,F,Z,L}
//   wb_valid, wb_addr, wb_data  one-cycle retirement report
//   dbg_sel / dbg_data          combinational register-file read (no bypass)
module regfile_datapath_pipe #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [AW-1:0]    a_sel,
  input  logic [AW-1:0]    b_sel,
  input  logic [AW-1:0]    dst_sel,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] immediate,
  input  logic             wb_en,
  output logic [4:0]       flags,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'd0, OP_ADDC = 4'd1, OP_SUB = 4'd2, OP_CMP = 4'd3,
                         OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_MOV = 4'd7,
                         OP_LSH = 4'd8, OP_RSH = 4'd9, OP_MUL = 4'd10;
  typedef enum logic [1:0] {IDLE, EXEC, MUL_RUN} exState_t;
  exState_t exState, exStateNext;
  logic [WIDTH-1:0] regs [NREGS];
  logic [4:0] flagsQ, flagsNext;
  logic readyEn, idValid, idUseImm, idWbEn, exWbEn;
  logic [3:0] idOp, exOp;
  logic [AW-1:0] idA, idB, idDst, exDst;
  logic [WIDTH-1:0] idImm, exA, exB, mulAcc, mulAccNext, result, opA, opB;
  logic [SW-1:0] mulCnt;
  logic [WIDTH:0] sum, diff;
  logic exDone, exWrite, idAdvance, take;
  assign exDone = exState == EXEC || (exState == MUL_RUN && mulCnt == SW'(WIDTH - 1));
  assign exWrite = exDone && exWbEn && exOp != OP_CMP && exOp <= OP_MUL;
  assign idAdvance = idValid && (exState == IDLE || exDone);
  // readyEn keeps in_ready low until the first edge after reset releases
  assign in_ready = readyEn && (!idValid || idAdvance);
  assign take = in_valid && in_ready;
  // operands forwarded from an EX result retiring on the same edge they are latched
  assign opA = exWrite && exDst == idA ? result : regs[idA];
  assign opB = idUseImm ? idImm : exWrite && exDst == idB ? result : regs[idB];
  assign flags = flagsQ;
  assign dbg_data = regs[dbg_sel];
  always_comb begin
    sum = {1'b0, exA} + {1'b0, exB} + {{WIDTH{1'b0}}, exOp == OP_ADDC && flagsQ[3]};
    diff = {1'b0, exA} - {1'b0, exB};
    mulAccNext = mulAcc + (exB[0] ? exA : '0);
    case (exOp)
      OP_ADD, OP_ADDC: result = sum[WIDTH-1:0];
      OP_SUB, OP_CMP:  result = diff[WIDTH-1:0];
      OP_AND:          result = exA & exB;
      OP_OR:           result = exA | exB;
      OP_XOR:          result = exA ^ exB;
      OP_MOV:          result = exB;
      OP_LSH:          result = exA << exB[SW-1:0];
      OP_RSH:          result = exA >> exB[SW-1:0];
      OP_MUL:          result = mulAccNext;
      default:         result = '0;
    endcase
    flagsNext = flagsQ;
    if (exOp <= OP_MUL) begin
      flagsNext[4] = result[WIDTH-1];
      flagsNext[1] = result == '0;
    end
    if (exOp <= OP_ADDC) begin
      flagsNext[3] = sum[WIDTH];
      flagsNext[2] = exA[WIDTH-1] == exB[WIDTH-1] && result[WIDTH-1] != exA[WIDTH-1];
    end
    if (exOp == OP_SUB || exOp == OP_CMP) begin
      flagsNext[3] = diff[WIDTH];
      flagsNext[2] = exA[WIDTH-1] != exB[WIDTH-1] && result[WIDTH-1] != exA[WIDTH-1];
      flagsNext[0] = diff[WIDTH];
    end
  end
  always_comb begin
    exStateNext = exState;
    if (idAdvance) exStateNext = idOp == OP_MUL ? MUL_RUN : EXEC;
    else if (exDone) exStateNext = IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) exState <= IDLE;
    else exState <= exStateNext;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readyEn <= 1'b0;
      idValid <= 1'b0;
      idOp <= '0;
      idA <= '0;
      idB <= '0;
      idDst <= '0;
      idUseImm <= 1'b0;
      idImm <= '0;
      idWbEn <= 1'b0;
    end else begin
      readyEn <= 1'b1;
      if (take) begin
        idValid <= 1'b1;
        idOp <= opcode;
        idA <= a_sel;
        idB <= b_sel;
        idDst <= dst_sel;
        idUseImm <= use_imm;
        idImm <= immediate;
        idWbEn <= wb_en;
      end else if (idAdvance) idValid <= 1'b0;
    end
  end
  // MUL walks the multiplier LSB-first: exA doubles and exB halves every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exOp <= '0;
      exDst <= '0;
      exWbEn <= 1'b0;
      exA <= '0;
      exB <= '0;
      mulAcc <= '0;
      mulCnt <= '0;
    end else if (idAdvance) begin
      exOp <= idOp;
      exDst <= idDst;
      exWbEn <= idWbEn;
      exA <= opA;
      exB <= opB;
      mulAcc <= '0;
      mulCnt <= '0;
    end else if (exState == MUL_RUN) begin
      mulAcc <= mulAccNext;
      exA <= exA << 1;
      exB <= exB >> 1;
      mulCnt <= mulCnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flagsQ <= '0;
      wb_valid <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      if (exWrite) regs[exDst] <= result;
      if (exDone) flagsQ <= flagsNext;
      wb_valid <= exDone;
      if (exDone) begin
        wb_addr <= exDst;
        wb_data <= result;
      end
    end
  end
endmodule
